// File: rtl/traffic_light_monitor.sv
// Passive checker for the two-road traffic-light interface: follows the 8-phase
// light sequence, flags illegal codes, transitions and sensor-rule violations.
module traffic_light_monitor #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample,
  input  logic [2:0]       la,
  input  logic [2:0]       lb,
  input  logic             sa,
  input  logic             sb,
  output logic             locked,
  output logic [3:0]       phase,
  output logic             err,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] rounds,
  output logic [CNT_W-1:0] b_green_len
);

  typedef enum logic [3:0] {
    S_SYNC   = 4'd0,
    S_A_GO   = 4'd1,
    S_A_YEL  = 4'd2,
    S_RR1    = 4'd3,
    S_B_YEL  = 4'd4,
    S_B_GO   = 4'd5,
    S_B_YEL2 = 4'd6,
    S_RR2    = 4'd7,
    S_A_YEL2 = 4'd8
  } phase_e;

  typedef enum logic [1:0] {L_R, L_Y, L_G, L_X} light_e;

  localparam logic [2:0] E_NONE = 3'd0;
  localparam logic [2:0] E_CODE = 3'd1;
  localparam logic [2:0] E_TRAN = 3'd2;
  localparam logic [2:0] E_BOTH = 3'd3;
  localparam logic [2:0] E_ASNS = 3'd4;
  localparam logic [2:0] E_BSNS = 3'd5;

  function automatic light_e dec(input logic [2:0] c);
    case (c)
      3'b111:  return L_R;
      3'b011:  return L_G;
      3'b001:  return L_Y;
      default: return L_X;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  phase_e           r_state, w_nxt;
  logic             r_req, r_err;
  logic [2:0]       r_err_code, w_code;
  logic [CNT_W-1:0] r_rounds, r_blen, r_dwell;
  light_e           w_a, w_b;
  logic             w_gr, w_yr, w_rr, w_ry, w_rg;

  assign w_a  = dec(la);
  assign w_b  = dec(lb);
  assign w_gr = (w_a == L_G) && (w_b == L_R);
  assign w_yr = (w_a == L_Y) && (w_b == L_R);
  assign w_rr = (w_a == L_R) && (w_b == L_R);
  assign w_ry = (w_a == L_R) && (w_b == L_Y);
  assign w_rg = (w_a == L_R) && (w_b == L_G);

  always_ff @(posedge clk) begin
    if (!reset)      r_state <= S_SYNC;
    else if (sample) r_state <= w_nxt;
  end

  // Error priority: both-green, then illegal code, then sequence, then sensors.
  always_comb begin
    w_nxt  = r_state;
    w_code = E_NONE;
    if (w_a == L_G && w_b == L_G)       w_code = E_BOTH;
    else if (w_a == L_X || w_b == L_X)  w_code = E_CODE;
    else begin
      case (r_state)
        S_SYNC:   if (w_gr) w_nxt = S_A_GO;
        S_A_GO: begin
          if (w_gr)      begin if (r_req) w_code = E_ASNS; end
          else if (w_yr) begin if (!r_req) w_code = E_ASNS; else w_nxt = S_A_YEL; end
          else           w_code = E_TRAN;
        end
        S_A_YEL:  if (w_rr) w_nxt = S_RR1;    else w_code = E_TRAN;
        S_RR1:    if (w_ry) w_nxt = S_B_YEL;  else w_code = E_TRAN;
        S_B_YEL:  if (w_rg) w_nxt = S_B_GO;   else w_code = E_TRAN;
        S_B_GO: begin
          if (w_rg)      begin if (!r_req) w_code = E_BSNS; end
          else if (w_ry) begin if (r_req) w_code = E_BSNS; else w_nxt = S_B_YEL2; end
          else           w_code = E_TRAN;
        end
        S_B_YEL2: if (w_rr) w_nxt = S_RR2;    else w_code = E_TRAN;
        S_RR2:    if (w_yr) w_nxt = S_A_YEL2; else w_code = E_TRAN;
        S_A_YEL2: if (w_gr) w_nxt = S_A_GO;   else w_code = E_TRAN;
        default:  w_nxt = S_SYNC;
      endcase
    end
    if (w_code != E_NONE) w_nxt = S_SYNC;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_req      <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= E_NONE;
      r_rounds   <= '0;
      r_blen     <= '0;
      r_dwell    <= '0;
    end else if (sample) begin
      r_req <= ~sa & sb;
      if (w_code != E_NONE) begin
        r_err <= 1'b1;
        if (!r_err) r_err_code <= w_code;
      end
      // Entry sample counts as the first B-green sample.
      if (w_nxt == S_B_GO)
        r_dwell <= (r_state == S_B_GO) ? sat_inc(r_dwell) : CNT_W'(1);
      if (r_state == S_B_GO && w_nxt == S_B_YEL2) r_blen <= r_dwell;
      if (r_state == S_A_YEL2 && w_nxt == S_A_GO) r_rounds <= sat_inc(r_rounds);
    end
  end

  assign locked      = (r_state != S_SYNC);
  assign phase       = r_state;
  assign err         = r_err;
  assign err_code    = r_err_code;
  assign rounds      = r_rounds;
  assign b_green_len = r_blen;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed + randomized bench for traffic_light_monitor against a rule-level
// reference model (phase numbers, successor arithmetic and a pair table).
module tb_traffic_light_monitor;
  localparam int CNT_W = 4;
  localparam int MAX   = (1 << CNT_W) - 1;
  localparam logic [2:0] R = 3'b111, G = 3'b011, Y = 3'b001;

  logic clk = 1'b0, reset = 1'b0, sample = 1'b0;
  logic [2:0] la = R, lb = R;
  logic sa = 1'b0, sb = 1'b0;
  logic locked, err;
  logic [3:0] phase;
  logic [2:0] err_code;
  logic [CNT_W-1:0] rounds, b_green_len;

  traffic_light_monitor #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .sample(sample), .la(la), .lb(lb), .sa(sa), .sb(sb),
    .locked(locked), .phase(phase), .err(err), .err_code(err_code),
    .rounds(rounds), .b_green_len(b_green_len)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int m_phase = 0, m_rounds = 0, m_blen = 0, m_dwell = 0, m_code = 0;
  bit m_err = 0, m_req = 0;

  function automatic logic [5:0] pair_of(input int p);
    case (p)
      1:       return {G, R};
      2, 8:    return {Y, R};
      3, 7:    return {R, R};
      4, 6:    return {R, Y};
      5:       return {R, G};
      default: return 6'h00;
    endcase
  endfunction

  function automatic bit legal(input logic [2:0] c);
    return (c == R) || (c == G) || (c == Y);
  endfunction

  function automatic int sat(input int v);
    return (v >= MAX) ? MAX : v + 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model(input logic [2:0] a, input logic [2:0] b, input logic s_a,
                       input logic s_b, input logic smp, input logic rst_n);
    int code, nxt, side;
    bit want_go;
    logic [5:0] pr;
    if (!rst_n) begin
      m_phase = 0; m_err = 0; m_code = 0; m_rounds = 0; m_blen = 0; m_dwell = 0; m_req = 0;
      return;
    end
    if (!smp) return;
    pr = {a, b};
    code = 0;
    nxt = m_phase % 8 + 1;
    if (a == G && b == G)            code = 3;
    else if (!legal(a) || !legal(b)) code = 1;
    else if (m_phase == 0)           nxt = (pr == {G, R}) ? 1 : 0;
    else if (m_phase == 1 || m_phase == 5) begin
      want_go = (m_phase == 1) ? m_req : !m_req;
      side    = (m_phase == 1) ? 4 : 5;
      if (pr == pair_of(m_phase)) begin
        if (want_go) code = side;
        nxt = m_phase;
      end else if (pr == pair_of(nxt)) begin
        if (!want_go) code = side;
      end else code = 2;
    end else if (pr != pair_of(nxt)) code = 2;
    if (code != 0) begin
      if (!m_err) m_code = code;
      m_err = 1;
      nxt = 0;
    end
    if (nxt == 5) m_dwell = (m_phase == 5) ? sat(m_dwell) : 1;
    if (m_phase == 5 && nxt == 6) m_blen = m_dwell;
    if (m_phase == 8 && nxt == 1) m_rounds = sat(m_rounds);
    m_phase = nxt;
    m_req = !s_a && s_b;
  endtask

  task automatic check_all();
    chk("locked", 32'(locked), 32'(m_phase != 0));
    chk("phase", 32'(phase), m_phase);
    chk("err", 32'(err), 32'(m_err));
    chk("err_code", 32'(err_code), m_code);
    chk("rounds", 32'(rounds), m_rounds);
    chk("b_green_len", 32'(b_green_len), m_blen);
  endtask

  // Drive at negedge, let one posedge act, compare at the following negedge.
  task automatic step(input logic [2:0] a, input logic [2:0] b, input logic s_a,
                      input logic s_b, input logic smp = 1'b1, input logic rst_n = 1'b1);
    la = a; lb = b; sa = s_a; sb = s_b; sample = smp; reset = rst_n;
    model(a, b, s_a, s_b, smp, rst_n);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [5:0] pr;
    logic cs_a, cs_b, smp, rs;
    int p;
    @(negedge clk);
    // reset and lock
    step(R, R, 0, 0, 1, 0);
    chk("rst_phase", 32'(phase), 0); chk("rst_err", 32'(err), 0);
    step(G, R, 1, 0);
    chk("lock_phase", 32'(phase), 1); chk("lock_locked", 32'(locked), 1);
    // one full legal round, B-green dwell of 3
    step(G, R, 0, 1);
    step(Y, R, 0, 1); step(R, R, 0, 1); step(R, Y, 0, 1);
    step(R, G, 0, 1); step(R, G, 0, 1); step(R, G, 0, 0);
    chk("bgo_phase", 32'(phase), 5);
    step(R, Y, 0, 0); step(R, R, 0, 0); step(Y, R, 0, 0);
    chk("ayel2_phase", 32'(phase), 8);
    step(G, R, 1, 0);
    chk("round_phase", 32'(phase), 1); chk("rounds1", 32'(rounds), 1);
    chk("blen3", 32'(b_green_len), 3); chk("round_err", 32'(err), 0);
    // A-side sensor rule: staying green with a pending request
    step(G, R, 0, 1); step(G, R, 0, 1);
    chk("asns_code", 32'(err_code), 4); chk("asns_phase", 32'(phase), 0);
    chk("asns_locked", 32'(locked), 0); chk("asns_rounds", 32'(rounds), 1);
    // illegal transition in RR1; later both-green must not overwrite
    step(R, R, 0, 0, 1, 0);
    step(G, R, 0, 1); step(Y, R, 0, 1); step(R, R, 0, 1); step(R, R, 0, 1);
    chk("tran_code", 32'(err_code), 2);
    step(G, G, 0, 0);
    chk("sticky_code", 32'(err_code), 2);
    // illegal code beats illegal transition while locked
    step(R, R, 0, 0, 1, 0);
    step(G, R, 0, 0); step(3'b010, R, 0, 0);
    chk("code1", 32'(err_code), 1);
    // both green
    step(R, R, 0, 0, 1, 0);
    step(G, G, 0, 0);
    chk("code3", 32'(err_code), 3);
    // transition error beats sensor error in A_GO
    step(R, R, 0, 0, 1, 0);
    step(G, R, 0, 1); step(R, R, 0, 1);
    chk("tran_over_sns", 32'(err_code), 2);
    // sample held low mid-B_GO, then reset
    step(R, R, 0, 0, 1, 0);
    step(G, R, 0, 1); step(Y, R, 0, 1); step(R, R, 0, 1); step(R, Y, 0, 1); step(R, G, 0, 1);
    for (int i = 0; i < 5; i++) step(3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 0, 1);
    chk("hold_phase", 32'(phase), 5); chk("hold_err", 32'(err), 0);
    step(R, G, 0, 1, 1, 0);
    chk("rst2_phase", 32'(phase), 0); chk("rst2_rounds", 32'(rounds), 0);
    // randomized: mostly a legal controller, occasional corruption
    cs_a = 1'b0; cs_b = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) cs_a = ~cs_a;
      if ($urandom_range(0, 5) == 0) cs_b = ~cs_b;
      p = m_phase;
      if (p == 0)      pr = pair_of(1);
      else if (p == 1) pr = m_req ? pair_of(2) : pair_of(1);
      else if (p == 5) pr = m_req ? pair_of(5) : pair_of(6);
      else             pr = pair_of(p % 8 + 1);
      if ((p == 1 || p == 5) && $urandom_range(0, 199) == 0)
        pr = (pr == pair_of(p)) ? pair_of(p + 1) : pair_of(p);
      if ($urandom_range(0, 99) == 0) pr = 6'($urandom);
      smp = ($urandom_range(0, 9) != 0);
      rs  = ($urandom_range(0, 499) != 0);
      step(pr[5:3], pr[2:0], cs_a, cs_b, smp, rs);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
